command_queue_ctrl: RTL and testbench
=====================================

# command_queue_ctrl

Parametrised single-clock host command front end for the GPU. Samples the host command strobe into the pipeline clock domain and queues command/data pairs in a DEPTH-entry FIFO. Presents the pairs to the GPU pipeline one per accepted cycle under `gpuBusy` backpressure, and numbers block-transfer beats. It adds three behaviours to the interface-plus-buffer pairing it supersedes: queue depth, reset-command flush, and sticky overflow/illegal reporting.

## Interface
Parameters:
- CMD_W, 16, command width; must be ≥ 8.
- DATA_W, 16, data word width.
- DEPTH, 8, FIFO entries; must be a power of two, ≥ 2.
- BEAT_W, 8, block beat counter width.

Ports:
- pipelineClk  in  1  the single clock for the whole block.
- rst  in  1  synchronous, active-low reset.
- chipSelect  in  1  active-low; the strobe is ignored while high.
- commandClk  in  1  host command strobe, asynchronous; its rising edge marks a new command.
- inputCommand  in  CMD_W  host command.
- dataIn  in  DATA_W  host data, captured with the command.
- gpuBusy  in  1  the GPU cannot accept the output this cycle.
- gpuValid  out  1  the output stage holds a command.
- gpuCommand  out  CMD_W  presented command.
- gpuData  out  DATA_W  presented data.
- gpuBeat  out  BEAT_W  beat index of the presented command within its block.
- fifoLevel  out  $clog2(DEPTH)+1  number of FIFO entries occupied, excluding the output stage.
- overflow  out  1  sticky; set when a command is dropped because the FIFO is full.
- illegal  out  1  sticky; set when a command is dropped by the filter.

## Operation
- Command fields:
  - type = cmd[CMD_W-1:CMD_W-2]: 00 reset, 01 read, 10 write, 11 reserved.
  - target = cmd[CMD_W-3:CMD_W-5].
- Strobe handling:
  - `commandClk` passes through a 2-flop synchroniser (s1, s2) plus a delay flop s3.
  - An edge is detected when s2 = 1 and s3 = 0.
  - On an edge with `chipSelect` = 0, {inputCommand, dataIn} is captured and written to the FIFO that cycle.
  - The host holds command and data stable from the `commandClk` rise until 4 `pipelineClk` cycles later.
- Output stage:
  - A registered stage drives gpuValid/gpuCommand/gpuData/gpuBeat.
  - The stage is consumed in any cycle where gpuValid = 1 and gpuBusy = 0.
  - The stage loads the FIFO head when it is empty or consumed.
  - Throughput: 1 command per cycle.
  - Outputs hold steady while gpuBusy = 1.
- Beat numbering:
  - On load, if the new command is type 01/10 and equals the last consumed command with no intervening different command, gpuBeat = previous beat + 1. The counter wraps modulo 2^BEAT_W.
  - Otherwise gpuBeat = 0.
- Reset command (type 00) at capture:
  - Clears the FIFO, the output stage, beat history, overflow and illegal.
  - Then the reset command is the only entry: it is loaded into the output stage directly, so gpuValid = 1 the next cycle.
- FIFO full:
  - When the FIFO is full at capture with no pop that cycle, the command is dropped and overflow is set.
  - A capture and a pop in the same cycle while full: the write is accepted and fifoLevel stays at DEPTH.
- FIFO empty with the output stage empty: a capture bypasses nothing; it enters the FIFO and loads into the output stage the next cycle.
- Reset (rst = 0): all outputs 0, FIFO empty, synchroniser flops 0. Reset taken mid-transfer discards every queued entry.

## Timing
- From the `commandClk` rise, s2 is high 2 cycles later, at which point the edge is detected and the FIFO is written.
- From the FIFO write to gpuValid = 1 is 1 cycle when the output stage is free, giving 3–4 cycles from strobe to GPU.
- Minimum host strobe period is 4 cycles, counting `commandClk` high plus low at ≥ 2 cycles each.
- A consumed output is replaced by the next head in the following cycle, with no bubble.
- Sticky flags update the cycle after the drop.

## Configuration
- CMDQ_ILLEGAL_FILTER_EN defined:
  - Commands of type 11, or with target 101/110/111, are dropped at capture and set illegal.
  - They never occupy the FIFO.
- CMDQ_ILLEGAL_FILTER_EN undefined: every command is queued unchanged, and illegal is tied to 0.

## Structure
- Package cmdq_pkg holds:
  - Type encodings (CMD_RESET, CMD_READ, CMD_WRITE, CMD_RSVD).
  - Target encodings (ALL, LAYER_HDR, RAM, PALETTE, FLASH).
  - Field-position localparams derived from CMD_W.
- One sub-module, cmdq_sync_fifo: a parametrised DATA_W+CMD_W × DEPTH synchronous FIFO with a flush input, level output, and simultaneous push/pop. The synchroniser, filter, output stage and beat logic live in the top.

## Test plan
- Single write: cmd 0x9000, data 0x1234, gpuBusy = 0 → gpuValid rises 3–4 cycles after the strobe with 0x9000/0x1234 and gpuBeat 0; it is consumed next cycle.
- Block write: five strobes of cmd 0x9008 with data 1..5 → gpuBeat 0,1,2,3,4 in order. A following 0x9010 → gpuBeat 0.
- Backpressure: gpuBusy held at 1, 9 strobes with DEPTH = 8 → the first command is held in the output stage, fifoLevel = 8, and overflow = 1 on the 10th strobe. Releasing gpuBusy drains 9 commands in 9 consecutive cycles.
- Reset command: 4 commands queued under busy, then a strobe of cmd 0x0000 → fifoLevel = 0, flags cleared, and 0x0000 presented next cycle, followed by nothing.
- Filter: with CMDQ_ILLEGAL_FILTER_EN, cmd 0xC000 and 0xA800 → both dropped and illegal = 1. Without the macro, both are presented.
- Ignored strobe: chipSelect = 1 during a strobe → no FIFO write. An rst pulse mid-queue → all outputs 0 the cycle after.

Source files
------------

// File: rtl/cmdq_pkg.sv
// Shared command queue definitions: command type/target encodings and
// helpers that locate the type and target fields for a given command width.
package cmdq_pkg;

  localparam int TYPE_W = 2;
  localparam int TGT_W  = 3;

  typedef enum logic [TYPE_W-1:0] {
    CMD_RESET = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_type_e;

  // Encodings above TGT_FLASH are unassigned targets.
  typedef enum logic [TGT_W-1:0] {
    TGT_ALL       = 3'd0,
    TGT_LAYER_HDR = 3'd1,
    TGT_RAM       = 3'd2,
    TGT_PALETTE   = 3'd3,
    TGT_FLASH     = 3'd4
  } cmd_target_e;

  function automatic int type_lsb(input int cmd_w);
    return cmd_w - TYPE_W;
  endfunction

  function automatic int tgt_lsb(input int cmd_w);
    return cmd_w - TYPE_W - TGT_W;
  endfunction

  function automatic logic is_block_type(input cmd_type_e t);
    return (t == CMD_READ) || (t == CMD_WRITE);
  endfunction

endpackage

// File: rtl/cmdq_sync_fifo.sv
// Synchronous FIFO with flush, occupancy level and same-cycle push/pop;
// a push while full is accepted only when a pop frees a slot that cycle.
module cmdq_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/command_queue_ctrl.sv
// Host command front end: strobe synchroniser, optional illegal-command filter
// (CMDQ_ILLEGAL_FILTER_EN), command queue and registered GPU output stage with beat numbering.
module command_queue_ctrl
  import cmdq_pkg::*;
#(
  parameter int CMD_W  = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int BEAT_W = 8
) (
  input  logic                   pipelineClk,
  input  logic                   rst,
  input  logic                   chipSelect,
  input  logic                   commandClk,
  input  logic [CMD_W-1:0]       inputCommand,
  input  logic [DATA_W-1:0]      dataIn,
  input  logic                   gpuBusy,
  output logic                   gpuValid,
  output logic [CMD_W-1:0]       gpuCommand,
  output logic [DATA_W-1:0]      gpuData,
  output logic [BEAT_W-1:0]      gpuBeat,
  output logic [$clog2(DEPTH):0] fifoLevel,
  output logic                   overflow,
  output logic                   illegal
);

  localparam int TYPE_LSB = type_lsb(CMD_W);
  localparam int ENTRY_W  = CMD_W + DATA_W;

  // Strobe synchroniser (s1, s2) and edge-detect delay flop (s3).
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge pipelineClk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= commandClk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  logic      capture, cap_illegal, cap_reset, fifo_push;
  cmd_type_e cap_type;

  assign capture  = s2_q & ~s3_q & ~chipSelect;
  assign cap_type = cmd_type_e'(inputCommand[TYPE_LSB +: TYPE_W]);

`ifdef CMDQ_ILLEGAL_FILTER_EN
  localparam int TGT_LSB = tgt_lsb(CMD_W);
  logic [TGT_W-1:0] cap_tgt;
  assign cap_tgt     = inputCommand[TGT_LSB +: TGT_W];
  assign cap_illegal = capture & ((cap_type == CMD_RSVD) | (cap_tgt > TGT_FLASH));
`else
  assign cap_illegal = 1'b0;
`endif

  // A reset command bypasses the queue and goes straight to the output stage.
  assign cap_reset = capture & ~cap_illegal & (cap_type == CMD_RESET);
  assign fifo_push = capture & ~cap_illegal & ~cap_reset;

  // Output stage and consumed-command history.
  logic              valid_q, valid_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              hist_valid_q, hist_valid_d;
  logic [CMD_W-1:0]  hist_cmd_q, hist_cmd_d;
  logic [BEAT_W-1:0] hist_beat_q, hist_beat_d;
  logic              ovf_q, ovf_d;
  logic              ill_q, ill_d;

  // Handshake: the stage transfers on any cycle with gpuValid=1 and gpuBusy=0;
  // otherwise it holds command, data and beat unchanged.
  logic consume, stage_free, fifo_pop;
  logic fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CMD_W-1:0]   head_cmd;
  logic [DATA_W-1:0]  head_data;
  cmd_type_e          head_type;

  assign consume    = valid_q & ~gpuBusy;
  assign stage_free = ~valid_q | consume;
  assign fifo_pop   = stage_free & ~fifo_empty & ~cap_reset;
  assign {head_cmd, head_data} = fifo_rdata;
  assign head_type  = cmd_type_e'(head_cmd[TYPE_LSB +: TYPE_W]);

  cmdq_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (pipelineClk),
    .rst_ni  (rst),
    .flush_i (cap_reset),
    .push_i  (fifo_push),
    .wdata_i ({inputCommand, dataIn}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (fifoLevel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The command leaving the stage this cycle counts as the last consumed one.
  logic              ref_valid;
  logic [CMD_W-1:0]  ref_cmd;
  logic [BEAT_W-1:0] ref_beat, next_beat;

  always_comb begin
    ref_valid = consume ? 1'b1   : hist_valid_q;
    ref_cmd   = consume ? cmd_q  : hist_cmd_q;
    ref_beat  = consume ? beat_q : hist_beat_q;
    next_beat = '0;
    if (ref_valid && is_block_type(head_type) && (head_cmd == ref_cmd))
      next_beat = ref_beat + 1'b1;
  end

  always_comb begin
    valid_d     = valid_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    beat_d      = beat_q;
    hist_valid_d = hist_valid_q;
    hist_cmd_d  = hist_cmd_q;
    hist_beat_d = hist_beat_q;
    ovf_d       = ovf_q | (fifo_push & fifo_full & ~fifo_pop);
    ill_d       = ill_q | cap_illegal;
    if (consume) begin
      hist_valid_d = 1'b1;
      hist_cmd_d   = cmd_q;
      hist_beat_d  = beat_q;
    end
    if (cap_reset) begin
      valid_d      = 1'b1;
      cmd_d        = inputCommand;
      data_d       = dataIn;
      beat_d       = '0;
      hist_valid_d = 1'b0;
      ovf_d        = 1'b0;
      ill_d        = 1'b0;
    end else if (fifo_pop) begin
      valid_d = 1'b1;
      cmd_d   = head_cmd;
      data_d  = head_data;
      beat_d  = next_beat;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge pipelineClk) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      cmd_q        <= '0;
      data_q       <= '0;
      beat_q       <= '0;
      hist_valid_q <= 1'b0;
      hist_cmd_q   <= '0;
      hist_beat_q  <= '0;
      ovf_q        <= 1'b0;
      ill_q        <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      beat_q       <= beat_d;
      hist_valid_q <= hist_valid_d;
      hist_cmd_q   <= hist_cmd_d;
      hist_beat_q  <= hist_beat_d;
      ovf_q        <= ovf_d;
      ill_q        <= ill_d;
    end
  end

  assign gpuValid   = valid_q;
  assign gpuCommand = cmd_q;
  assign gpuData    = data_q;
  assign gpuBeat    = beat_q;
  assign overflow   = ovf_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_command_queue_ctrl.sv
// Bench for command_queue_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized strobes and backpressure.
`timescale 1ns/1ps
module tb_command_queue_ctrl;

  localparam int CMD_W  = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int BEAT_W = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  // Clock / reset / DUT
  logic pipelineClk = 1'b0;
  logic rst = 1'b0;
  logic chipSelect = 1'b0;
  logic commandClk = 1'b0;
  logic gpuBusy = 1'b0;
  logic [CMD_W-1:0]  inputCommand = '0;
  logic [DATA_W-1:0] dataIn = '0;
  logic              gpuValid;
  logic [CMD_W-1:0]  gpuCommand;
  logic [DATA_W-1:0] gpuData;
  logic [BEAT_W-1:0] gpuBeat;
  logic [LVL_W-1:0]  fifoLevel;
  logic              overflow;
  logic              illegal;

  always #5 pipelineClk = ~pipelineClk;

  command_queue_ctrl #(
    .CMD_W (CMD_W), .DATA_W (DATA_W), .DEPTH (DEPTH), .BEAT_W (BEAT_W)
  ) dut (
    .pipelineClk  (pipelineClk),
    .rst          (rst),
    .chipSelect   (chipSelect),
    .commandClk   (commandClk),
    .inputCommand (inputCommand),
    .dataIn       (dataIn),
    .gpuBusy      (gpuBusy),
    .gpuValid     (gpuValid),
    .gpuCommand   (gpuCommand),
    .gpuData      (gpuData),
    .gpuBeat      (gpuBeat),
    .fifoLevel    (fifoLevel),
    .overflow     (overflow),
    .illegal      (illegal)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  bit rand_busy = 1'b0;
  int busy_pct = 50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the queue holds {cmd,data}; captures are scheduled by the driver
  // for the third clock edge after the strobe rise.
  typedef struct { int at; logic [15:0] cmd; logic [15:0] data; bit cs; } cap_t;
  typedef struct { logic [15:0] cmd; logic [15:0] data; logic [7:0] beat; int cyc; } obs_t;

  logic [CMD_W+DATA_W-1:0] exp_q[$];
  cap_t cap_sched[$];
  obs_t seen[$];

  bit          m_valid = 0, h_valid = 0, m_ovf = 0, m_ill = 0;
  logic [15:0] m_cmd = '0, m_data = '0, h_cmd = '0;
  logic [7:0]  m_beat = '0, h_beat = '0;
  bit          m_consume, m_cap, m_cap_ill, m_cap_rst, m_cap_push;
  logic [15:0] c_cmd, c_data;
  logic [31:0] ent;
  cap_t        sc;

  initial forever begin
    @(posedge pipelineClk);
    cyc++;
    m_cap = 0;
    c_cmd = '0;
    c_data = '0;
    while (cap_sched.size() > 0 && cap_sched[0].at < cyc) void'(cap_sched.pop_front());
    if (cap_sched.size() > 0 && cap_sched[0].at == cyc) begin
      sc = cap_sched.pop_front();
      m_cap = !sc.cs;
      c_cmd = sc.cmd;
      c_data = sc.data;
    end
    if (!rst) begin
      exp_q.delete();
      cap_sched.delete();
      m_valid = 0; m_cmd = '0; m_data = '0; m_beat = '0;
      h_valid = 0; m_ovf = 0; m_ill = 0;
    end else begin
      m_consume = m_valid && !gpuBusy;
      m_cap_ill = 0;
`ifdef CMDQ_ILLEGAL_FILTER_EN
      if (m_cap && (c_cmd[15:14] == 2'd3 || c_cmd[13:11] >= 3'd5)) m_cap_ill = 1;
`endif
      m_cap_rst  = m_cap && !m_cap_ill && c_cmd[15:14] == 2'd0;
      m_cap_push = m_cap && !m_cap_ill && c_cmd[15:14] != 2'd0;
      if (m_consume) begin
        h_valid = 1; h_cmd = m_cmd; h_beat = m_beat;
      end
      if (m_cap_rst) begin
        exp_q.delete();
        m_valid = 1; m_cmd = c_cmd; m_data = c_data; m_beat = '0;
        h_valid = 0; m_ovf = 0; m_ill = 0;
      end else begin
        if ((!m_valid || m_consume) && exp_q.size() > 0) begin
          ent = exp_q.pop_front();
          if (h_valid && (ent[31:30] == 2'd1 || ent[31:30] == 2'd2) && ent[31:16] == h_cmd)
            m_beat = h_beat + 8'd1;
          else
            m_beat = '0;
          m_cmd = ent[31:16]; m_data = ent[15:0]; m_valid = 1;
        end else if (m_consume) begin
          m_valid = 0;
        end
        if (m_cap_push) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({c_cmd, c_data});
          else m_ovf = 1;
        end
        if (m_cap_ill) m_ill = 1;
      end
    end
  end

  // Scoreboard compare on the falling edge, plus a log of consumed outputs.
  initial forever begin
    @(negedge pipelineClk);
    if (cmp_en) begin
      chk("valid", 32'(gpuValid), 32'(m_valid));
      chk("level", 32'(fifoLevel), 32'(exp_q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("illegal", 32'(illegal), 32'(m_ill));
      if (m_valid) begin
        chk("cmd", 32'(gpuCommand), 32'(m_cmd));
        chk("data", 32'(gpuData), 32'(m_data));
        chk("beat", 32'(gpuBeat), 32'(m_beat));
      end
      if (gpuValid === 1'b1 && gpuBusy === 1'b0)
        seen.push_back('{gpuCommand, gpuData, gpuBeat, cyc});
    end
  end

  // Driver tasks (inputs change 2 ns after the rising edge).
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pipelineClk);
      #2;
      if (rand_busy) gpuBusy = ($urandom_range(0, 99) < busy_pct);
    end
  endtask

  task automatic rise(input logic [15:0] c, input logic [15:0] d, input bit cs);
    inputCommand = c;
    dataIn = d;
    chipSelect = cs;
    commandClk = 1'b1;
    cap_sched.push_back('{cyc + 3, c, d, cs});
  endtask

  task automatic strobe(input logic [15:0] c, input logic [15:0] d, input bit cs);
    rise(c, d, cs);
    tick(2);
    commandClk = 1'b0;
    tick(2);
    chipSelect = 1'b0;
  endtask

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  logic [15:0] rc;

  initial begin
    rst = 1'b0;
    tick(3);
    cmp_en = 1'b1;
    chk("rst_valid", 32'(gpuValid), 32'h0);
    chk("rst_cmd", 32'(gpuCommand), 32'h0);
    chk("rst_data", 32'(gpuData), 32'h0);
    chk("rst_beat", 32'(gpuBeat), 32'h0);
    chk("rst_level", 32'(fifoLevel), 32'h0);
    chk("rst_flags", 32'({overflow, illegal}), 32'h0);
    rst = 1'b1;
    tick(2);

    // Single write and its latency.
    seen.delete();
    rise(16'h9000, 16'h1234, 1'b0);
    tick(2);
    commandClk = 1'b0;
    tick(1);
    chk("single_early", 32'(gpuValid), 32'h0);
    tick(1);
    chk("single_valid", 32'(gpuValid), 32'h1);
    chk("single_cmd", 32'(gpuCommand), 32'h9000);
    chk("single_data", 32'(gpuData), 32'h1234);
    chk("single_beat", 32'(gpuBeat), 32'h0);
    tick(1);
    chk("single_consumed", 32'(gpuValid), 32'h0);
    tick(1);

    // Block write beats.
    seen.delete();
    for (int i = 1; i <= 5; i++) strobe(16'h9008, 16'(i), 1'b0);
    tick(3);
    chk("block_count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      chk("block_beat", 32'(seen[i].beat), 32'(i));
      chk("block_data", 32'(seen[i].data), 32'(i + 1));
    end
    strobe(16'h9010, 16'h0006, 1'b0);
    tick(3);
    chk("block_new_count", 32'(seen.size()), 32'd6);
    if (seen.size() == 6) chk("block_new_beat", 32'(seen[5].beat), 32'h0);

    // Backpressure and overflow.
    seen.delete();
    gpuBusy = 1'b1;
    for (int i = 0; i < 9; i++) strobe(16'h9008, 16'(i), 1'b0);
    chk("bp_level", 32'(fifoLevel), 32'd8);
    chk("bp_hold_valid", 32'(gpuValid), 32'h1);
    chk("bp_hold_data", 32'(gpuData), 32'h0);
    chk("bp_no_ovf", 32'(overflow), 32'h0);
    strobe(16'h9008, 16'd9, 1'b0);
    chk("bp_ovf", 32'(overflow), 32'h1);
    chk("bp_level_full", 32'(fifoLevel), 32'd8);
    gpuBusy = 1'b0;
    tick(12);
    chk("drain_count", 32'(seen.size()), 32'd9);
    for (int i = 0; i < 9 && i < seen.size(); i++) begin
      chk("drain_data", 32'(seen[i].data), 32'(i));
      chk("drain_beat", 32'(seen[i].beat), 32'(i));
      chk("drain_cycle", 32'(seen[i].cyc - seen[0].cyc), 32'(i));
    end
    chk("drain_ovf_sticky", 32'(overflow), 32'h1);

    // Reset command flushes the queue.
    seen.delete();
    gpuBusy = 1'b1;
    for (int i = 0; i < 4; i++) strobe(16'h4000, 16'(16'h0100 + i), 1'b0);
    chk("rc_level_before", 32'(fifoLevel), 32'd3);
    strobe(16'h0000, 16'hABCD, 1'b0);
    chk("rc_level", 32'(fifoLevel), 32'h0);
    chk("rc_valid", 32'(gpuValid), 32'h1);
    chk("rc_cmd", 32'(gpuCommand), 32'h0000);
    chk("rc_data", 32'(gpuData), 32'hABCD);
    chk("rc_flags", 32'({overflow, illegal}), 32'h0);
    gpuBusy = 1'b0;
    tick(4);
    chk("rc_only_one", 32'(seen.size()), 32'd1);
    chk("rc_idle", 32'(gpuValid), 32'h0);

    // Illegal command handling.
    seen.delete();
    strobe(16'hC000, 16'h0011, 1'b0);
    strobe(16'hA800, 16'h0022, 1'b0);
    tick(3);
`ifdef CMDQ_ILLEGAL_FILTER_EN
    chk("filt_dropped", 32'(seen.size()), 32'd0);
    chk("filt_illegal", 32'(illegal), 32'h1);
`else
    chk("filt_passed", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      chk("filt_cmd0", 32'(seen[0].cmd), 32'hC000);
      chk("filt_cmd1", 32'(seen[1].cmd), 32'hA800);
    end
    chk("filt_illegal", 32'(illegal), 32'h0);
`endif

    // Strobe ignored while chipSelect is high.
    seen.delete();
    strobe(16'h9000, 16'h0055, 1'b1);
    tick(3);
    chk("cs_ignored", 32'(seen.size()), 32'd0);
    chk("cs_level", 32'(fifoLevel), 32'h0);

    // Reset pulse mid-queue.
    gpuBusy = 1'b1;
    for (int i = 0; i < 3; i++) strobe(16'h8000, 16'(i), 1'b0);
    chk("mid_level", 32'(fifoLevel), 32'd2);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_valid", 32'(gpuValid), 32'h0);
    chk("mid_rst_cmd", 32'(gpuCommand), 32'h0);
    chk("mid_rst_data", 32'(gpuData), 32'h0);
    chk("mid_rst_level", 32'(fifoLevel), 32'h0);
    chk("mid_rst_flags", 32'({overflow, illegal}), 32'h0);
    rst = 1'b1;
    gpuBusy = 1'b0;
    tick(2);

    // Randomized strobes under random backpressure.
    rand_busy = 1'b1;
    for (int n = 0; n < 160; n++) begin
      busy_pct = (n < 80) ? 50 : 90;
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4: rc = 16'h9008;
        5, 6:          rc = 16'h4010;
        7:             rc = 16'h8000;
        8:             rc = 16'h0000;
        9:             rc = 16'hC000;
        10:            rc = 16'hA800;
        default: begin
          rc = 16'($urandom);
          if (rc[15:14] == 2'b00) rc[15:14] = 2'b10;
        end
      endcase
      strobe(rc, 16'($urandom), $urandom_range(0, 9) == 0);
      tick($urandom_range(0, 2));
    end
    rand_busy = 1'b0;
    gpuBusy = 1'b0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
